// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and constants for the dot-product sequencer and its operand bank.
package dot_product_sequencer_pkg;

  localparam int unsigned OPW = 2;
  localparam int unsigned RW  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/dot_product_sequencer_operand_bank.sv
// Operand-pair register file: one write port, one combinational read port, async clear.
module dot_product_sequencer_operand_bank
  import dot_product_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  operand_pair_t wdata,
  input  logic [AW-1:0] raddr,
  output operand_pair_t rdata_c
);

  operand_pair_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams operand pairs to an external FSM+MAC, waits out its pipeline and captures the sum.
// Optional self-check against an internal reference: define DOTSEQ_EXPECT_EN.
module dot_product_sequencer
  import dot_product_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned AW            = $clog2(DEPTH),
  parameter int unsigned CAPTURE_DELAY = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_en,
  input  logic [AW-1:0]  load_addr,
  input  logic [OPW-1:0] load_a,
  input  logic [OPW-1:0] load_b,
  input  logic [AW:0]    len,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [RW-1:0]  result,
  output logic [OPW-1:0] a,
  output logic [OPW-1:0] b,
  output logic           run,
  output logic           clear,
  input  logic [RW-1:0]  mac_out
`ifdef DOTSEQ_EXPECT_EN
  ,
  output logic           mismatch,
  output logic           overflow
`endif
);

  localparam int unsigned DW = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(CAPTURE_DELAY - 1);
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);

  state_e         state_q, state_d;
  logic [AW:0]    idx_q, idx_d;
  logic [AW:0]    eff_len_q, eff_len_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           busy_d, done_d, run_d, clear_d;
  logic [RW-1:0]  result_d;
  logic [OPW-1:0] a_d, b_d;
  operand_pair_t  rd_c;
  logic           bank_we_c;

`ifdef DOTSEQ_EXPECT_EN
  logic [9:0] ref_q, ref_d;
  logic       mismatch_d, overflow_d;
`endif

  // Bank is writable only while idle so a running vector never changes underneath.
  assign bank_we_c = load_en && (state_q == IDLE);

  dot_product_sequencer_operand_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (bank_we_c),
    .waddr   (load_addr),
    .wdata   ('{a: load_a, b: load_b}),
    .raddr   (idx_q[AW-1:0]),
    .rdata_c (rd_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      eff_len_q <= '0;
      drain_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      a         <= '0;
      b         <= '0;
      run       <= 1'b0;
      clear     <= 1'b0;
`ifdef DOTSEQ_EXPECT_EN
      ref_q     <= '0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      eff_len_q <= eff_len_d;
      drain_q   <= drain_d;
      busy      <= busy_d;
      done      <= done_d;
      result    <= result_d;
      a         <= a_d;
      b         <= b_d;
      run       <= run_d;
      clear     <= clear_d;
`ifdef DOTSEQ_EXPECT_EN
      ref_q     <= ref_d;
      mismatch  <= mismatch_d;
      overflow  <= overflow_d;
`endif
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    eff_len_d = eff_len_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    run_d     = 1'b0;
    clear_d   = 1'b0;
    a_d       = '0;
    b_d       = '0;
    result_d  = result;
`ifdef DOTSEQ_EXPECT_EN
    ref_d      = ref_q;
    mismatch_d = mismatch;
    overflow_d = overflow;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          eff_len_d = (len > DEPTH_L) ? DEPTH_L : len;
          idx_d     = '0;
          clear_d   = 1'b1;
          state_d   = CLEAR;
`ifdef DOTSEQ_EXPECT_EN
          ref_d     = '0;
`endif
        end
      end
      CLEAR, ISSUE: begin
        // idx counts pairs already issued; stop once it reaches the latched length.
        if (idx_q == eff_len_q) begin
          drain_d = DRAIN_INIT;
          state_d = DRAIN;
        end else begin
          run_d   = 1'b1;
          a_d     = rd_c.a;
          b_d     = rd_c.b;
          idx_d   = idx_q + 1'b1;
          state_d = ISSUE;
`ifdef DOTSEQ_EXPECT_EN
          ref_d   = ref_q + 10'(rd_c.a) * 10'(rd_c.b);
`endif
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          done_d   = 1'b1;
          result_d = mac_out;
          state_d  = DONE;
`ifdef DOTSEQ_EXPECT_EN
          mismatch_d = (ref_q[7:0] != mac_out);
          overflow_d = (ref_q > 10'd255);
`endif
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
